// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: run-control
// states and the PC stepping / alignment constants.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // Byte distance between consecutive instruction words.
  localparam int PC_STEP    = 4;

  // Clears the two low address bits. This is a signed int (-4), so a size
  // cast sign-extends it and keeps every upper bit set at any width.
  localparam int ALIGN_MASK = ~3;

endpackage

// File: rtl/fetch_bounds_check.sv
// Word-index bounds comparator for the fetch PC. It flags any word index
// that lies beyond the end of the program ROM. The top-level module only
// instantiates it when FETCH_BOUNDS_CHECK_EN is defined.
module fetch_bounds_check #(
  parameter int IDX_WIDTH    = 30,
  parameter int MEMORY_DEPTH = 32
) (
  input  logic [IDX_WIDTH-1:0] idx_i,
  output logic                 oob_o
);

  // Compare at a fixed wide width, so the depth constant is never truncated.
  assign oob_o = 64'(idx_i) >= 64'(MEMORY_DEPTH);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer. It owns the fetch PC, addresses the
// combinational program ROM, and registers each returned word together with
// its PC into a valid/ready output slot for decode. The block supports
// redirect, start/stop run control, and a handshake counter.
// Optional feature: defining FETCH_BOUNDS_CHECK_EN enables the ROM bounds
// check. When enabled, an out-of-range fetch sets fault_o and halts the block.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                  DATA_WIDTH   = 32,
  parameter int                  MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic [DATA_WIDTH-1:0] mem_address_o,
  input  logic [DATA_WIDTH-1:0] mem_instruction_i,
  output logic [DATA_WIDTH-1:0] instruction_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [31:0]           instr_count_o,
  output logic                  fault_o
);

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic [31:0]           count_q, count_d;
  logic                  fault_q, fault_d;

  logic want_load;
  logic load;
  logic fault_hit;
  logic handshake;
  logic redirect_take;
  logic oob;

`ifdef FETCH_BOUNDS_CHECK_EN
  fetch_bounds_check #(
    .IDX_WIDTH    (DATA_WIDTH - 2),
    .MEMORY_DEPTH (MEMORY_DEPTH)
  ) u_bounds_check (
    .idx_i (fetch_pc_q[DATA_WIDTH-1:2]),
    .oob_o (oob)
  );
`else
  assign oob = 1'b0;
`endif

  // Load, handshake and redirect qualifiers shared by every next-state equation.
  assign want_load     = (state_q == RUN) && (!valid_q || ready_i) && !redirect_i && !stop_i;
  assign load          = want_load && !oob;
  assign fault_hit     = want_load && oob;
  assign handshake     = valid_q && ready_i;
  assign redirect_take = redirect_i && (state_q != HALT);

  assign mem_address_o = fetch_pc_q;
  assign instruction_o = instr_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_q + DATA_WIDTH'(PC_STEP);
  assign valid_o       = valid_q;
  assign instr_count_o = count_q;
  assign fault_o       = fault_q;

  // Next-state logic: run control, fetch PC, output slot, counter and fault flag.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    count_d    = count_q + {31'd0, handshake};
    fault_d    = fault_q | fault_hit;

    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN: begin
        if (stop_i)         state_d = IDLE;
        else if (fault_hit) state_d = HALT;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase

    if (redirect_take) begin
      fetch_pc_d = redirect_pc_i & DATA_WIDTH'(ALIGN_MASK);
      valid_d    = 1'b0;
    end else if (load) begin
      fetch_pc_d = fetch_pc_q + DATA_WIDTH'(PC_STEP);
      instr_d    = mem_instruction_i;
      pc_d       = fetch_pc_q;
      valid_d    = 1'b1;
    end else if (handshake) begin
      valid_d    = 1'b0;
    end
  end

  // State and datapath registers, cleared immediately by the active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      instr_q    <= '0;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      count_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      fault_q    <= fault_d;
    end
  end

endmodule
